missile_pool: RTL

Multi-missile successor to the single-missile mover. Manages NUM_MISSILES independent player-missile slots from one shared fire request and one ship position. Adds lowest-free-slot allocation, a per-frame fire cooldown, per-slot collision clearing and optional off-screen retirement. Sits between the keyboard/ship logic and the missile drawers and collision matrix, with one X/Y/active lane per slot.

---
 rtl/missile_pkg.sv | 20 ++
 rtl/missile_slot.sv | 93 +++++++++
 rtl/missile_pool.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/missile_pkg.sv
// ---------------------------------------------------------------------------
// missile_pkg
// Shared fixed-point definitions for the missile pool and its slots.
//   FP_SHIFT / FP_MULT : positions are held as 32-bit signed values scaled x64
//   fp_t               : signed 32-bit fixed-point position type
//   to_pixel()         : fixed point -> pixel, arithmetic shift (floors toward -inf)
// ---------------------------------------------------------------------------
package missile_pkg;

    localparam int FP_SHIFT = 6;
    localparam int FP_MULT  = 1 << FP_SHIFT;

    typedef logic signed [31:0] fp_t;

    // Arithmetic shift keeps the sign, so negative positions floor toward -inf.
    function automatic fp_t to_pixel(input fp_t value);
        return value >>> FP_SHIFT;
    endfunction

endpackage

// File: rtl/missile_slot.sv
// ---------------------------------------------------------------------------
// missile_slot
// One missile: holds a fixed-point X/Y accumulator and an active flag.
// Ports:
//   clk, resetN            : clock, asynchronous active-low reset
//   spawn_i                : load spawnX_i/spawnY_i and go active
//   move_i                 : frame tick, add X_SPEED/Y_SPEED when active
//   collision_i            : hit, go inactive and clear position
//   spawnX_i, spawnY_i     : fixed-point spawn position
//   active_o               : slot is on screen
//   pixelX_o, pixelY_o     : signed pixel position, 0 when inactive
// Optional: define MISSILE_OFFSCREEN_KILL_EN to retire a missile whose new
// pixel Y leaves [Y_MIN, Y_MAX] on a movement update.
// ---------------------------------------------------------------------------
module missile_slot
    import missile_pkg::*;
#(
    parameter int PIXEL_WIDTH = 11,
    parameter int X_SPEED     = 0,
    parameter int Y_SPEED     = -256,
    parameter int Y_MIN       = -32,
    parameter int Y_MAX       = 479
) (
    input  logic                          clk,
    input  logic                          resetN,
    input  logic                          spawn_i,
    input  logic                          move_i,
    input  logic                          collision_i,
    input  fp_t                           spawnX_i,
    input  fp_t                           spawnY_i,
    output logic                          active_o,
    output logic signed [PIXEL_WIDTH-1:0] pixelX_o,
    output logic signed [PIXEL_WIDTH-1:0] pixelY_o
);

    logic active_q, active_d;
    fp_t  posX_q, posX_d;
    fp_t  posY_q, posY_d;
    fp_t  nextX, nextY;
`ifdef MISSILE_OFFSCREEN_KILL_EN
    logic signed [PIXEL_WIDTH-1:0] nextPixY;
`endif

    // Collision wins over spawn, spawn wins over movement. The accumulators
    // wrap on overflow; there is deliberately no saturation.
    always_comb begin
        active_d = active_q;
        posX_d   = posX_q;
        posY_d   = posY_q;
        nextX    = posX_q + fp_t'(X_SPEED);
        nextY    = posY_q + fp_t'(Y_SPEED);
`ifdef MISSILE_OFFSCREEN_KILL_EN
        nextPixY = PIXEL_WIDTH'(to_pixel(nextY));
`endif
        if (collision_i) begin
            active_d = 1'b0;
            posX_d   = '0;
            posY_d   = '0;
        end else if (spawn_i) begin
            active_d = 1'b1;
            posX_d   = spawnX_i;
            posY_d   = spawnY_i;
        end else if (move_i && active_q) begin
            posX_d = nextX;
            posY_d = nextY;
`ifdef MISSILE_OFFSCREEN_KILL_EN
            // Retire in the same clk so the out-of-range Y is never shown.
            if (int'(nextPixY) < Y_MIN || int'(nextPixY) > Y_MAX) begin
                active_d = 1'b0;
                posX_d   = '0;
                posY_d   = '0;
            end
`endif
        end
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            active_q <= 1'b0;
            posX_q   <= '0;
            posY_q   <= '0;
        end else begin
            active_q <= active_d;
            posX_q   <= posX_d;
            posY_q   <= posY_d;
        end
    end

    assign active_o = active_q;
    assign pixelX_o = active_q ? PIXEL_WIDTH'(to_pixel(posX_q)) : '0;
    assign pixelY_o = active_q ? PIXEL_WIDTH'(to_pixel(posY_q)) : '0;

endmodule

// File: rtl/missile_pool.sv
// ---------------------------------------------------------------------------
// missile_pool
// Manages NUM_MISSILES player-missile slots from one fire request and one
// ship position: lowest-free-slot allocation, per-frame fire cooldown,
// per-slot collision clearing.
// Ports:
//   clk, resetN           : clock, asynchronous active-low reset
//   startOfFrame          : one-clk pulse per frame
//   shotKeyIsPress        : fire request pulse, any clk
//   collision             : per-slot hit, bit i clears slot i
//   spaceShip_X/_Y        : ship top-left position (unsigned, zero-extended)
//   topLeftX/topLeftY     : packed signed pixel X/Y, slot i at [i*PW +: PW]
//   missile_active        : per-slot on-screen flag
//   fire_ack              : one-clk pulse when a shot is allocated
//   fire_slot             : index of the most recent allocation
//   free_count            : number of inactive slots
// Optional: define MISSILE_OFFSCREEN_KILL_EN to retire missiles leaving
// the [Y_MIN, Y_MAX] pixel band (handled inside missile_slot).
// ---------------------------------------------------------------------------
module missile_pool
    import missile_pkg::*;
#(
    parameter int NUM_MISSILES    = 4,
    parameter int PIXEL_WIDTH     = 11,
    parameter int X_SPEED         = 0,
    parameter int Y_SPEED         = -256,
    parameter int X_OFFSET        = 16,
    parameter int COOLDOWN_FRAMES = 2,
    parameter int Y_MIN           = -32,
    parameter int Y_MAX           = 479,
    localparam int SLOT_W = (NUM_MISSILES > 1) ? $clog2(NUM_MISSILES) : 1,
    localparam int CNT_W  = $clog2(NUM_MISSILES + 1)
) (
    input  logic                                clk,
    input  logic                                resetN,
    input  logic                                startOfFrame,
    input  logic                                shotKeyIsPress,
    input  logic [NUM_MISSILES-1:0]             collision,
    input  logic [PIXEL_WIDTH-1:0]              spaceShip_X,
    input  logic [PIXEL_WIDTH-1:0]              spaceShip_Y,
    output logic [NUM_MISSILES*PIXEL_WIDTH-1:0] topLeftX,
    output logic [NUM_MISSILES*PIXEL_WIDTH-1:0] topLeftY,
    output logic [NUM_MISSILES-1:0]             missile_active,
    output logic                                fire_ack,
    output logic [SLOT_W-1:0]                   fire_slot,
    output logic [CNT_W-1:0]                    free_count
);

    localparam int CD_W = (COOLDOWN_FRAMES > 0) ? $clog2(COOLDOWN_FRAMES + 1) : 1;

    logic              shotPending_q, shotPending_d;
    logic [CD_W-1:0]   cooldown_q, cooldown_d;
    logic              fireAck_q, fireAck_d;
    logic [SLOT_W-1:0] fireSlot_q, fireSlot_d;

    logic              slotFound;
    logic [SLOT_W-1:0] slotSel;
    logic              fireNow;
    logic [NUM_MISSILES-1:0] spawnVec, moveVec;
    fp_t               spawnX, spawnY;

    // Ship coordinates are unsigned; zero-extend before adding the offset.
    assign spawnX = ($signed({{(32-PIXEL_WIDTH){1'b0}}, spaceShip_X}) + fp_t'(X_OFFSET)) <<< FP_SHIFT;
    assign spawnY = $signed({{(32-PIXEL_WIDTH){1'b0}}, spaceShip_Y}) <<< FP_SHIFT;

    // Lowest-index free slot. A slot being hit this clk is skipped because
    // the collision clear owns it for this clk.
    always_comb begin
        slotFound = 1'b0;
        slotSel   = '0;
        for (int i = NUM_MISSILES - 1; i >= 0; i--) begin
            if (!missile_active[i] && !collision[i]) begin
                slotFound = 1'b1;
                slotSel   = SLOT_W'(i);
            end
        end
    end

    assign fireNow = startOfFrame && shotPending_q && (cooldown_q == '0) && slotFound;

    // The freshly spawned slot skips movement on its spawn frame.
    always_comb begin
        spawnVec = '0;
        moveVec  = '0;
        for (int i = 0; i < NUM_MISSILES; i++) begin
            spawnVec[i] = fireNow && (slotSel == SLOT_W'(i));
            moveVec[i]  = startOfFrame && !spawnVec[i];
        end
    end

    // A request is served or dropped at every frame boundary; a press landing
    // on the boundary clk itself is carried into the next frame.
    always_comb begin
        shotPending_d = startOfFrame ? shotKeyIsPress : (shotPending_q | shotKeyIsPress);
        cooldown_d    = cooldown_q;
        if (fireNow) begin
            cooldown_d = CD_W'(COOLDOWN_FRAMES);
        end else if (startOfFrame && cooldown_q != '0) begin
            cooldown_d = cooldown_q - CD_W'(1);
        end
        fireAck_d  = fireNow;
        fireSlot_d = fireNow ? slotSel : fireSlot_q;
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            shotPending_q <= 1'b0;
            cooldown_q    <= '0;
            fireAck_q     <= 1'b0;
            fireSlot_q    <= '0;
        end else begin
            shotPending_q <= shotPending_d;
            cooldown_q    <= cooldown_d;
            fireAck_q     <= fireAck_d;
            fireSlot_q    <= fireSlot_d;
        end
    end

    genvar g;
    generate
        for (g = 0; g < NUM_MISSILES; g++) begin : gSlot
            missile_slot #(
                .PIXEL_WIDTH (PIXEL_WIDTH),
                .X_SPEED     (X_SPEED),
                .Y_SPEED     (Y_SPEED),
                .Y_MIN       (Y_MIN),
                .Y_MAX       (Y_MAX)
            ) uSlot (
                .clk         (clk),
                .resetN      (resetN),
                .spawn_i     (spawnVec[g]),
                .move_i      (moveVec[g]),
                .collision_i (collision[g]),
                .spawnX_i    (spawnX),
                .spawnY_i    (spawnY),
                .active_o    (missile_active[g]),
                .pixelX_o    (topLeftX[g*PIXEL_WIDTH +: PIXEL_WIDTH]),
                .pixelY_o    (topLeftY[g*PIXEL_WIDTH +: PIXEL_WIDTH])
            );
        end
    endgenerate

    always_comb begin
        free_count = '0;
        for (int i = 0; i < NUM_MISSILES; i++) begin
            free_count = free_count + CNT_W'(!missile_active[i]);
        end
    end

    assign fire_ack  = fireAck_q;
    assign fire_slot = fireSlot_q;

endmodule
